// File: rtl/fusion_pkg.sv
// fusion_pkg: shared constants and sizing helpers for the fusion chain; stall=1 freezes every fusion stage and the upstream source
package fusion_pkg;
  localparam int PIXEL_W = 8;
  function automatic int row_beats(input int image_dim, input int pixels_per_beat);
    return image_dim / pixels_per_beat;
  endfunction
  function automatic int clog2(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/skid_fifo2.sv
// skid_fifo2: two-entry FIFO exposing head data, occupancy and full
module skid_fifo2 #(
  parameter int DATA_WIDTH = 128
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] head,
  output logic [1:0]            count,
  output logic                  full
);
  logic [DATA_WIDTH-1:0] mem [2];
  logic wr_ptr, rd_ptr;
  // pointers and occupancy; the owner never pushes when full nor pops when empty
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      wr_ptr <= wr_ptr ^ push;
      rd_ptr <= rd_ptr ^ pop;
      count  <= count + {1'b0, push} - {1'b0, pop};
    end
  // storage is unreset; its contents are qualified by count
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= din;
  assign head = mem[rd_ptr];
  assign full = count == 2'd2;
endmodule

// File: rtl/fusion_stream_out.sv
// fusion_stream_out: AXI4-Stream video master behind the two-stage stall-gated fusion datapath
module fusion_stream_out
  import fusion_pkg::*;
#(
  parameter int PIXELS_PER_BEAT = 16,
  parameter int IMAGE_DIM       = 512,
  parameter int DATA_WIDTH      = PIXEL_W * PIXELS_PER_BEAT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] fused_frame,
  output logic                  stall,
  output logic [DATA_WIDTH-1:0] m_tdata,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic                  m_tlast,
  output logic                  m_tuser,
  output logic                  frame_done
);
  localparam int ROW_BEATS = row_beats(IMAGE_DIM, PIXELS_PER_BEAT);
  localparam int CW = clog2(ROW_BEATS);
  localparam int RW = clog2(IMAGE_DIM);
  localparam logic [CW-1:0] COL_LAST = CW'(ROW_BEATS - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMAGE_DIM - 1);
  if (IMAGE_DIM % PIXELS_PER_BEAT != 0) begin : g_bad_dim
    $error("IMAGE_DIM must be a multiple of PIXELS_PER_BEAT");
  end
  logic          v1, v2, push, pop, col_end, frame_end;
  logic [1:0]    count;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  assign push      = v2 & ~stall;
  assign pop       = m_tvalid & m_tready;
  assign m_tvalid  = count != 2'd0;
  assign col_end   = col == COL_LAST;
  assign frame_end = col_end & (row == ROW_LAST);
  assign m_tlast   = col_end;
  assign m_tuser   = (col == '0) & (row == '0);
  skid_fifo2 #(.DATA_WIDTH(DATA_WIDTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   (fused_frame),
    .head  (m_tdata),
    .count (count),
    .full  (stall)
  );
  // validity shadow of the fusion block's two stall-gated register stages
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {v1, v2} <= 2'b00;
    else if (!stall) {v1, v2} <= {in_valid, v1};
  // head-beat position advances only on acceptance; frame_done follows the last beat of a frame
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      col        <= '0;
      row        <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= pop & frame_end;
      if (pop) begin
        col <= col_end ? '0 : col + 1'b1;
        if (col_end) row <= frame_end ? '0 : row + 1'b1;
      end
    end
endmodule

// File: tb/tb_fusion_stream_out.sv
// tb_fusion_stream_out: randomized scoreboard bench for fusion_stream_out
module tb_fusion_stream_out;
  localparam int PPB = 16;
  localparam int DIM = 64;
  localparam int DW  = 8 * PPB;
  localparam int RB  = DIM / PPB;
  localparam int FB  = RB * DIM;
  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, m_tready = 1'b1;
  logic [DW-1:0] in_data = '0, f1, f2;
  logic stall, m_tvalid, m_tlast, m_tuser, frame_done;
  logic [DW-1:0] m_tdata;
  int errors = 0, checks = 0, cyc = 0;
  logic [DW-1:0] exp_q[$], got_q[$];
  bit got_last[$], got_user[$];
  int got_cyc[$], fd_cyc[$];
  int first_acc = -1, first_val = -1;
  bit stall_seen = 0;
  fusion_stream_out #(.PIXELS_PER_BEAT(PPB), .IMAGE_DIM(DIM)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .fused_frame (f2),
    .stall       (stall),
    .m_tdata     (m_tdata),
    .m_tvalid    (m_tvalid),
    .m_tready    (m_tready),
    .m_tlast     (m_tlast),
    .m_tuser     (m_tuser),
    .frame_done  (frame_done)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      f1 <= '0;
      f2 <= '0;
    end else if (!stall) begin
      f1 <= in_data;
      f2 <= f1;
    end
  always @(negedge clk)
    if (rst_n) begin
      if (in_valid && !stall) begin
        exp_q.push_back(in_data);
        if (first_acc < 0) first_acc = cyc;
      end
      if (m_tvalid && first_val < 0) first_val = cyc;
      if (m_tvalid && m_tready) begin
        got_q.push_back(m_tdata);
        got_last.push_back(m_tlast);
        got_user.push_back(m_tuser);
        got_cyc.push_back(cyc);
      end
      if (frame_done) fd_cyc.push_back(cyc);
      if (stall) stall_seen = 1;
    end
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time expired, required completion");
    $fatal(1);
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic clear_sb();
    exp_q.delete();
    got_q.delete();
    got_last.delete();
    got_user.delete();
    got_cyc.delete();
    fd_cyc.delete();
    first_acc = -1;
    first_val = -1;
    stall_seen = 0;
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    m_tready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    clear_sb();
    rst_n = 1'b1;
    step();
  endtask
  task automatic send(input logic [DW-1:0] d, input bit v);
    bit ok;
    int n = 0;
    in_valid = v;
    in_data = d;
    do begin
      ok = !stall || !v;
      step();
      n++;
    end while (!ok && n < 500);
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: stall held %0d cycles, required release", n);
    end
    in_valid = 1'b0;
  endtask
  task automatic drain();
    int n = 0;
    m_tready = 1'b1;
    while ((got_q.size() < exp_q.size() || m_tvalid) && n < 2000) begin
      step();
      n++;
    end
    repeat (2) step();
  endtask
  function automatic logic [DW-1:0] rnd();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction
  task automatic test_reset();
    rst_n = 1'b0;
    step();
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b, required 0", stall); end
    checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid: got %b, required 0", m_tvalid); end
    checks++; if (m_tlast !== 1'b0) begin errors++; $display("FAIL reset_tlast: got %b, required 0", m_tlast); end
    checks++; if (m_tuser !== 1'b1) begin errors++; $display("FAIL reset_tuser: got %b, required 1", m_tuser); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done: got %b, required 0", frame_done); end
    do_reset();
  endtask
  task automatic test_streaming();
    do_reset();
    for (int i = 0; i < FB; i++) send(DW'(i), 1'b1);
    drain();
    checks++; if (got_q.size() != FB) begin errors++; $display("FAIL stream_count: got %0d, required %0d", got_q.size(), FB); end
    for (int i = 0; i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== DW'(i)) begin errors++; $display("FAIL stream_data[%0d]: got %h, required %h", i, got_q[i], DW'(i)); end
      checks++; if (got_last[i] !== (i % RB == RB - 1)) begin errors++; $display("FAIL stream_tlast[%0d]: got %b", i, got_last[i]); end
      checks++; if (got_user[i] !== (i % FB == 0)) begin errors++; $display("FAIL stream_tuser[%0d]: got %b", i, got_user[i]); end
    end
    checks++; if (first_val - first_acc != 3) begin errors++; $display("FAIL stream_latency: got %0d, required 3", first_val - first_acc); end
    checks++; if (stall_seen) begin errors++; $display("FAIL stream_stall: got 1, required never"); end
    checks++; if (fd_cyc.size() != 1) begin errors++; $display("FAIL stream_frame_done_count: got %0d, required 1", fd_cyc.size()); end
    if (fd_cyc.size() == 1 && got_cyc.size() == FB) begin
      checks++; if (fd_cyc[0] != got_cyc[FB-1] + 1) begin errors++; $display("FAIL stream_frame_done_time: got %0d, required %0d", fd_cyc[0], got_cyc[FB-1] + 1); end
    end
  endtask
  task automatic test_backpressure();
    do_reset();
    fork
      for (int i = 0; i < 20; i++) send(DW'(i), 1'b1);
      begin
        int n = 0, stall_at = 0;
        while (!(m_tvalid === 1'b1 && m_tdata === DW'(5)) && n < 100) begin
          step();
          n++;
        end
        checks++; if (n >= 100) begin errors++; $display("FAIL bp_find_beat5: got head %h, required 5", m_tdata); end
        m_tready = 1'b0;
        for (int k = 1; k <= 10; k++) begin
          step();
          checks++; if (m_tvalid !== 1'b1 || m_tdata !== DW'(5)) begin errors++; $display("FAIL bp_hold[%0d]: got valid=%b data=%h, required 1/5", k, m_tvalid, m_tdata); end
          if (stall && stall_at == 0) stall_at = k;
        end
        checks++; if (stall_at < 1 || stall_at > 2) begin errors++; $display("FAIL bp_stall_rise: got cycle %0d, required 1..2", stall_at); end
        m_tready = 1'b1;
        step();
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL bp_stall_fall: got %b, required 0", stall); end
      end
    join
    drain();
    checks++; if (got_q.size() != 20) begin errors++; $display("FAIL bp_count: got %0d, required 20", got_q.size()); end
    for (int i = 0; i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== DW'(i)) begin errors++; $display("FAIL bp_data[%0d]: got %h, required %h", i, got_q[i], DW'(i)); end
    end
  endtask
  task automatic test_random();
    bit src_done = 0;
    do_reset();
    fork
      begin
        int sent = 0;
        while (sent < 3 * FB) begin
          bit v = 1'($urandom_range(1));
          send(rnd(), v);
          if (v) sent++;
        end
        src_done = 1;
      end
      while (!src_done) begin
        m_tready = ($urandom_range(99) < 30);
        step();
      end
    join
    drain();
    checks++; if (got_q.size() != 3 * FB || exp_q.size() != 3 * FB) begin errors++; $display("FAIL rand_count: got %0d/%0d, required %0d", got_q.size(), exp_q.size(), 3 * FB); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand_data[%0d]: got %h, required %h", i, got_q[i], exp_q[i]); end
      checks++; if (got_last[i] !== (i % RB == RB - 1)) begin errors++; $display("FAIL rand_tlast[%0d]: got %b", i, got_last[i]); end
      checks++; if (got_user[i] !== (i % FB == 0)) begin errors++; $display("FAIL rand_tuser[%0d]: got %b", i, got_user[i]); end
    end
    checks++; if (fd_cyc.size() != 3) begin errors++; $display("FAIL rand_frame_done_count: got %0d, required 3", fd_cyc.size()); end
    for (int k = 0; k < fd_cyc.size() && FB * k + FB - 1 < got_cyc.size(); k++) begin
      checks++; if (fd_cyc[k] != got_cyc[FB*k+FB-1] + 1) begin errors++; $display("FAIL rand_frame_done_time[%0d]: got %0d, required %0d", k, fd_cyc[k], got_cyc[FB*k+FB-1] + 1); end
    end
  endtask
  task automatic test_simultaneous();
    do_reset();
    fork
      for (int i = 0; i < 30; i++) send(rnd(), 1'b1);
      begin
        repeat (5) step();
        for (int k = 0; k < 20; k++) begin
          checks++; if (stall !== 1'b0 || m_tvalid !== 1'b1) begin errors++; $display("FAIL simul[%0d]: got stall=%b valid=%b, required 0/1", k, stall, m_tvalid); end
          step();
        end
      end
    join
    drain();
    checks++; if (got_q.size() != 30) begin errors++; $display("FAIL simul_count: got %0d, required 30", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL simul_data[%0d]: got %h, required %h", i, got_q[i], exp_q[i]); end
    end
  endtask
  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 100; i++) send(rnd(), 1'b1);
    m_tready = 1'b0;
    in_valid = 1'b1;
    in_data = rnd();
    repeat (4) step();
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL rmid_full: got stall=%b, required 1", stall); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rmid_stall: got %b, required 0", stall); end
    checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL rmid_tvalid: got %b, required 0", m_tvalid); end
    checks++; if (m_tlast !== 1'b0) begin errors++; $display("FAIL rmid_tlast: got %b, required 0", m_tlast); end
    checks++; if (m_tuser !== 1'b1) begin errors++; $display("FAIL rmid_tuser: got %b, required 1", m_tuser); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL rmid_frame_done: got %b, required 0", frame_done); end
    in_valid = 1'b0;
    m_tready = 1'b1;
    step();
    clear_sb();
    rst_n = 1'b1;
    step();
    for (int i = 0; i < 8; i++) send(rnd(), 1'b1);
    drain();
    checks++; if (got_q.size() != 8) begin errors++; $display("FAIL rmid_count: got %0d, required 8", got_q.size()); end
    if (got_q.size() > 0) begin
      checks++; if (got_user[0] !== 1'b1 || got_last[0] !== 1'b0) begin errors++; $display("FAIL rmid_first_flags: got tuser=%b tlast=%b, required 1/0", got_user[0], got_last[0]); end
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rmid_data[%0d]: got %h, required %h", i, got_q[i], exp_q[i]); end
    end
  endtask
  task automatic test_frame_wrap();
    do_reset();
    for (int i = 0; i < 2 * FB; i++) send(rnd(), 1'b1);
    drain();
    checks++; if (got_q.size() != 2 * FB) begin errors++; $display("FAIL wrap_count: got %0d, required %0d", got_q.size(), 2 * FB); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL wrap_data[%0d]: got %h, required %h", i, got_q[i], exp_q[i]); end
      checks++; if (got_user[i] !== (i % FB == 0)) begin errors++; $display("FAIL wrap_tuser[%0d]: got %b", i, got_user[i]); end
      checks++; if (got_last[i] !== (i % RB == RB - 1)) begin errors++; $display("FAIL wrap_tlast[%0d]: got %b", i, got_last[i]); end
    end
    checks++; if (fd_cyc.size() != 2) begin errors++; $display("FAIL wrap_frame_done_count: got %0d, required 2", fd_cyc.size()); end
    for (int k = 0; k < fd_cyc.size() && FB * k + FB - 1 < got_cyc.size(); k++) begin
      checks++; if (fd_cyc[k] != got_cyc[FB*k+FB-1] + 1) begin errors++; $display("FAIL wrap_frame_done_time[%0d]: got %0d, required %0d", k, fd_cyc[k], got_cyc[FB*k+FB-1] + 1); end
    end
  endtask
  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_random();
    test_simultaneous();
    test_reset_mid();
    test_frame_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
